// File: rtl/register_write_pkg.sv
// Shared types, constants and helpers for the register-file write arbiter.
package register_write_pkg;

  localparam int RF_ADDR_WIDTH = 4;
  localparam int RF_DATA_WIDTH = 32;

  typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;
  typedef logic [RF_DATA_WIDTH-1:0] rf_data_t;

  // Register 0 doubles as the stack pointer and has its own write port.
  localparam int REG_STACK = 0;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter: one-hot grant over an eligibility mask, pointer
// advances past the winner.
module round_robin_arbiter
  import register_write_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] eligible,
  output logic [NUM_REQ-1:0] grant
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic             hi_found, lo_found;
  int               hi_sel, lo_sel, sel;

  always_comb begin
    hi_found    = 1'b0;
    lo_found    = 1'b0;
    hi_sel      = 0;
    lo_sel      = 0;
    sel         = 0;
    grant       = '0;
    rr_ptr_next = rr_ptr_reg;
    // Scan downwards so the lowest qualifying index wins; the "hi" scan
    // covers rr_ptr..NUM_REQ-1, the "lo" scan is the wrap-around fallback.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        lo_found = 1'b1;
        lo_sel   = i;
        if (i >= int'(rr_ptr_reg)) begin
          hi_found = 1'b1;
          hi_sel   = i;
        end
      end
    end
    sel = hi_found ? hi_sel : lo_sel;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i == sel) grant[i] = lo_found;
    end
    if (lo_found) rr_ptr_next = PTR_W'(rr_next(sel, NUM_REQ));
  end

  always_ff @(posedge clk) begin
    if (reset) rr_ptr_reg <= '0;
    else       rr_ptr_reg <= rr_ptr_next;
  end

endmodule

// File: rtl/register_write_arbiter.sv
// Arbitrates writeback requesters onto the register file's general write
// port and forwards stack-pointer updates to the register-0 port.
module register_write_arbiter
  import register_write_pkg::*;
#(
  parameter int ADDR_WIDTH_RF = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_REQ       = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              hold,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH_RF-1:0]  req_address,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_data,
  input  logic                              stack_valid,
  input  logic [DATA_WIDTH-1:0]             stack_data,
  output logic                              general_register_write_enable,
  output logic [ADDR_WIDTH_RF-1:0]          address_3,
  output logic [DATA_WIDTH-1:0]             general_register_write_data,
  output logic                              stack_write_enable,
  output logic [DATA_WIDTH-1:0]             stack_register_write_data,
  output logic [2**ADDR_WIDTH_RF-1:0]       write_pending
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH_RF;

  logic [NUM_REQ-1:0]       eligible, grant;
  logic                     grant_any;
  logic [ADDR_WIDTH_RF-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]    sel_data;
  logic [NUM_REGS-1:0]      pending_next;

  logic                     gen_we_reg;
  logic [ADDR_WIDTH_RF-1:0] gen_addr_reg;
  logic [DATA_WIDTH-1:0]    gen_data_reg;
  logic                     stack_we_reg;
  logic [DATA_WIDTH-1:0]    stack_data_reg;
  logic [NUM_REGS-1:0]      pending_reg;

  // A register-0 request waits while a stack write owns register 0 this cycle.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
      assign eligible[gi] = req_valid[gi] & ~hold & ~reset &
          ~(stack_valid &
            (req_address[gi*ADDR_WIDTH_RF +: ADDR_WIDTH_RF] == ADDR_WIDTH_RF'(REG_STACK)));
    end
  endgenerate

  round_robin_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk      (clk),
    .reset    (reset),
    .eligible (eligible),
    .grant    (grant)
  );

  assign req_ready = grant;
  assign grant_any = |grant;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_address[i*ADDR_WIDTH_RF +: ADDR_WIDTH_RF];
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    pending_next = '0;
    if (grant_any)   pending_next[sel_addr]  = 1'b1;
    if (stack_valid) pending_next[REG_STACK] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gen_we_reg     <= 1'b0;
      gen_addr_reg   <= '0;
      gen_data_reg   <= '0;
      stack_we_reg   <= 1'b0;
      stack_data_reg <= '0;
      pending_reg    <= '0;
    end else begin
      gen_we_reg   <= grant_any;
      stack_we_reg <= stack_valid;
      pending_reg  <= pending_next;
      if (grant_any) begin
        gen_addr_reg <= sel_addr;
        gen_data_reg <= sel_data;
      end
      if (stack_valid) stack_data_reg <= stack_data;
    end
  end

  assign general_register_write_enable = gen_we_reg;
  assign address_3                     = gen_addr_reg;
  assign general_register_write_data   = gen_data_reg;
  assign stack_write_enable            = stack_we_reg;
  assign stack_register_write_data     = stack_data_reg;
  assign write_pending                 = pending_reg;

endmodule

// File: tb/tb_register_write_arbiter.sv
// Directed bench for register_write_arbiter with a behavioural register file
// fed from the DUT's write-side ports.
module tb_register_write_arbiter;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int NR = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              hold;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*AW-1:0]  req_address;
  logic [NR*DW-1:0]  req_data;
  logic              stack_valid;
  logic [DW-1:0]     stack_data;
  logic              gwe;
  logic [AW-1:0]     address_3;
  logic [DW-1:0]     gwd;
  logic              swe;
  logic [DW-1:0]     swd;
  logic [2**AW-1:0]  write_pending;

  logic [DW-1:0]     rf [2**AW];

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  register_write_arbiter #(.ADDR_WIDTH_RF(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk                           (clk),
    .reset                         (reset),
    .hold                          (hold),
    .req_valid                     (req_valid),
    .req_ready                     (req_ready),
    .req_address                   (req_address),
    .req_data                      (req_data),
    .stack_valid                   (stack_valid),
    .stack_data                    (stack_data),
    .general_register_write_enable (gwe),
    .address_3                     (address_3),
    .general_register_write_data   (gwd),
    .stack_write_enable            (swe),
    .stack_register_write_data     (swd),
    .write_pending                 (write_pending)
  );

  // Register file model driven by the DUT write ports.
  always @(posedge clk) begin
    if (gwe) rf[address_3] <= gwd;
    if (swe) rf[0] <= swd;
  end

  // One line per accepted transfer.
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && req_ready[i])
          $display("[%0t] txn req%0d addr=%0d data=0x%08h", $time, i,
                   req_address[i*AW +: AW], req_data[i*DW +: DW]);
      end
      if (stack_valid) $display("[%0t] txn stack data=0x%08h", $time, stack_data);
    end
  end

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_address[i*AW +: AW] = a;
    req_data[i*DW +: DW]    = d;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    req_valid = 3'b111;
    set_req(0, 4'd1, 32'hA1);
    set_req(1, 4'd2, 32'hA2);
    set_req(2, 4'd3, 32'hA3);
    #1;
    total_cnt++;
    if (req_ready !== 3'b000) $display("FAIL reset_ready: got %b want 000", req_ready);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({gwe, address_3, gwd, swe, swd, write_pending} !== '0)
      $display("FAIL reset_outputs: gwe=%b a3=%0d gwd=%h swe=%b swd=%h wp=%h want all 0",
               gwe, address_3, gwd, swe, swd, write_pending);
    else pass_cnt++;
    reset = 1'b0;
    #1;
    total_cnt++;
    if (req_ready !== 3'b001) $display("FAIL reset_first_grant: got %b want 001", req_ready);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] exp_rdy  [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    logic [AW-1:0] exp_addr [4] = '{4'd1, 4'd2, 4'd3, 4'd1};
    logic [DW-1:0] exp_data [4] = '{32'hA1, 32'hA2, 32'hA3, 32'hA1};
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (req_ready !== exp_rdy[i]) $display("FAIL rr_ready[%0d]: got %b want %b", i, req_ready, exp_rdy[i]);
      else pass_cnt++;
      @(negedge clk);
      #1;
      total_cnt++;
      if (gwe !== 1'b1 || address_3 !== exp_addr[i] || gwd !== exp_data[i])
        $display("FAIL rr_out[%0d]: gwe=%b a3=%0d d=%h want 1/%0d/%h", i, gwe, address_3, gwd,
                 exp_addr[i], exp_data[i]);
      else pass_cnt++;
    end
    req_valid = 3'b000;
  endtask

  // rr_ptr is 1 on entry.
  task automatic test_reg0_conflict();
    @(negedge clk);
    stack_valid = 1'b1;
    stack_data  = 32'h100;
    req_valid   = 3'b010;
    set_req(1, 4'd0, 32'h55);
    #1;
    total_cnt++;
    if (req_ready !== 3'b000) $display("FAIL conflict_ready: got %b want 000", req_ready);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (swe !== 1'b1 || swd !== 32'h100 || write_pending !== 16'h0001 || gwe !== 1'b0)
      $display("FAIL conflict_stack: swe=%b swd=%h wp=%h gwe=%b want 1/100/0001/0", swe, swd, write_pending, gwe);
    else pass_cnt++;
    stack_valid = 1'b0;
    #1;
    total_cnt++;
    if (req_ready !== 3'b010) $display("FAIL conflict_retry_ready: got %b want 010", req_ready);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (gwe !== 1'b1 || address_3 !== 4'd0 || gwd !== 32'h55 || write_pending !== 16'h0001 || swe !== 1'b0)
      $display("FAIL conflict_general: gwe=%b a3=%0d d=%h wp=%h swe=%b want 1/0/55/0001/0",
               gwe, address_3, gwd, write_pending, swe);
    else pass_cnt++;
    total_cnt++;
    if (rf[0] !== 32'h100) $display("FAIL conflict_rf0_stack: got %h want 00000100", rf[0]);
    else pass_cnt++;
    req_valid = 3'b000;
    @(negedge clk);
    total_cnt++;
    if (rf[0] !== 32'h55 || gwe !== 1'b0 || write_pending !== 16'h0000)
      $display("FAIL conflict_rf0_general: rf0=%h gwe=%b wp=%h want 55/0/0000", rf[0], gwe, write_pending);
    else pass_cnt++;
  endtask

  // rr_ptr is 2 on entry.
  task automatic test_stall();
    @(negedge clk);
    req_valid = 3'b111;
    set_req(0, 4'd1, 32'hB1);
    set_req(1, 4'd2, 32'hB2);
    set_req(2, 4'd3, 32'hB3);
    #1;
    total_cnt++;
    if (req_ready !== 3'b100) $display("FAIL stall_pre_ready: got %b want 100", req_ready);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (gwe !== 1'b1 || address_3 !== 4'd3) $display("FAIL stall_pre_out: gwe=%b a3=%0d want 1/3", gwe, address_3);
    else pass_cnt++;
    hold = 1'b1;
    #1;
    total_cnt++;
    if (req_ready !== 3'b000) $display("FAIL stall_ready: got %b want 000", req_ready);
    else pass_cnt++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      total_cnt++;
      if (gwe !== 1'b0 || req_ready !== 3'b000)
        $display("FAIL stall_cycle[%0d]: gwe=%b ready=%b want 0/000", c, gwe, req_ready);
      else pass_cnt++;
    end
    hold = 1'b0;
    #1;
    total_cnt++;
    if (req_ready !== 3'b001) $display("FAIL stall_resume_ready: got %b want 001", req_ready);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (gwe !== 1'b1 || address_3 !== 4'd1 || gwd !== 32'hB1)
      $display("FAIL stall_resume_out: gwe=%b a3=%0d d=%h want 1/1/b1", gwe, address_3, gwd);
    else pass_cnt++;
    req_valid = 3'b000;
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    req_valid = 3'b100;
    set_req(2, 4'd5, 32'hDEAD);
    #1;
    total_cnt++;
    if (req_ready !== 3'b100) $display("FAIL mid_ready: got %b want 100", req_ready);
    else pass_cnt++;
    #1;
    reset = 1'b1;
    #1;
    total_cnt++;
    if (req_ready !== 3'b000) $display("FAIL mid_ready_in_reset: got %b want 000", req_ready);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (gwe !== 1'b0 || write_pending !== 16'h0000)
      $display("FAIL mid_discard: gwe=%b wp=%h want 0/0000", gwe, write_pending);
    else pass_cnt++;
    reset = 1'b0;
    #1;
    total_cnt++;
    if (req_ready !== 3'b100) $display("FAIL mid_regrant_ready: got %b want 100", req_ready);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (rf[5] !== 32'h0 || gwe !== 1'b1 || address_3 !== 4'd5 || gwd !== 32'hDEAD)
      $display("FAIL mid_regrant_out: rf5=%h gwe=%b a3=%0d d=%h want 0/1/5/dead", rf[5], gwe, address_3, gwd);
    else pass_cnt++;
    req_valid = 3'b000;
    @(negedge clk);
    total_cnt++;
    if (rf[5] !== 32'hDEAD) $display("FAIL mid_rf5: got %h want 0000dead", rf[5]);
    else pass_cnt++;
  endtask

  // rr_ptr is 0 on entry; stack and general write land in the same cycle.
  task automatic test_back_to_back();
    @(negedge clk);
    stack_valid = 1'b1;
    stack_data  = 32'h200;
    req_valid   = 3'b001;
    set_req(0, 4'd7, 32'h77);
    #1;
    total_cnt++;
    if (req_ready !== 3'b001) $display("FAIL dual_ready: got %b want 001", req_ready);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (write_pending !== 16'h0081 || gwe !== 1'b1 || swe !== 1'b1 || swd !== 32'h200)
      $display("FAIL dual_out: wp=%h gwe=%b swe=%b swd=%h want 0081/1/1/200", write_pending, gwe, swe, swd);
    else pass_cnt++;
    stack_valid = 1'b0;
    req_valid   = 3'b000;
    @(negedge clk);
    total_cnt++;
    if (rf[7] !== 32'h77 || rf[0] !== 32'h200 || gwe !== 1'b0 || swe !== 1'b0)
      $display("FAIL dual_rf: rf7=%h rf0=%h gwe=%b swe=%b want 77/200/0/0", rf[7], rf[0], gwe, swe);
    else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) rf[i] = '0;
    reset       = 1'b1;
    hold        = 1'b0;
    req_valid   = '0;
    req_address = '0;
    req_data    = '0;
    stack_valid = 1'b0;
    stack_data  = '0;
    test_reset();
    test_round_robin();
    test_reg0_conflict();
    test_stall();
    test_reset_midflight();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
